// File: rtl/instruction_encoder.sv
// RV32I instruction encoder: classifies a request by opcode, range-checks the
// immediate for its format, packs the 32-bit word and queues legal words in a FIFO.
module instruction_encoder #(
  parameter int DEPTH     = 4,
  parameter int WORD_SIZE = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               in_opcode,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [2:0]               in_funct3,
  input  logic [6:0]               in_funct7,
  input  logic [31:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_SIZE-1:0]     out_instruction,
  output logic [2:0]               out_type,
  output logic                     err,
  output logic [7:0]               err_count,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = WORD_SIZE + 3;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] TYPE_R = 3'b000;
  localparam logic [2:0] TYPE_I = 3'b001;
  localparam logic [2:0] TYPE_S = 3'b010;
  localparam logic [2:0] TYPE_U = 3'b011;
  localparam logic [2:0] TYPE_B = 3'b100;
  localparam logic [2:0] TYPE_J = 3'b101;

  // True when imm is exactly the sign-extension of its low 'bits' bits.
  function automatic logic fits_signed(input logic [31:0] imm, input int bits);
    logic signed [31:0] t;
    t = $signed(imm) <<< (32 - bits);
    t = t >>> (32 - bits);
    return (t == $signed(imm));
  endfunction

  function automatic logic [31:0] pack_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] pack_i(input logic [31:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
    return {imm[11:0], rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] pack_s(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  function automatic logic [31:0] pack_b(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [6:0] opc);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
  endfunction

  function automatic logic [31:0] pack_u(input logic [31:0] imm, input logic [4:0] rd,
                                         input logic [6:0] opc);
    return {imm[31:12], rd, opc};
  endfunction

  function automatic logic [31:0] pack_j(input logic [31:0] imm, input logic [4:0] rd,
                                         input logic [6:0] opc);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
  endfunction

  logic [WORD_SIZE-1:0] enc_word;
  logic [2:0]           enc_type;
  logic                 enc_legal;

  always_comb begin
    enc_word  = '0;
    enc_type  = TYPE_R;
    enc_legal = 1'b0;
    case (in_opcode)
      OPC_OP: begin
        enc_type  = TYPE_R;
        enc_legal = 1'b1;
        enc_word  = pack_r(in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode);
      end
      OPC_OP_IMM, OPC_JALR, OPC_LOAD: begin
        enc_type  = TYPE_I;
        enc_legal = fits_signed(in_imm, 12);
        enc_word  = pack_i(in_imm, in_rs1, in_funct3, in_rd, in_opcode);
      end
      OPC_STORE: begin
        enc_type  = TYPE_S;
        enc_legal = fits_signed(in_imm, 12);
        enc_word  = pack_s(in_imm, in_rs2, in_rs1, in_funct3, in_opcode);
      end
      OPC_BRANCH: begin
        enc_type  = TYPE_B;
        enc_legal = fits_signed(in_imm, 13) && !in_imm[0];
        enc_word  = pack_b(in_imm, in_rs2, in_rs1, in_funct3, in_opcode);
      end
      OPC_LUI, OPC_AUIPC: begin
        enc_type  = TYPE_U;
        enc_legal = (in_imm[11:0] == 12'h000);
        enc_word  = pack_u(in_imm, in_rd, in_opcode);
      end
      OPC_JAL: begin
        enc_type  = TYPE_J;
        enc_legal = fits_signed(in_imm, 21) && !in_imm[0];
        enc_word  = pack_j(in_imm, in_rd, in_opcode);
      end
      default: begin
        enc_legal = 1'b0;
      end
    endcase
  end

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [7:0]    err_count_q, err_count_d;

  logic accept, push, pop, reject;
  logic [EW-1:0] head;

  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && enc_legal;
  assign reject    = accept && !enc_legal;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    err_d       = reject;
    err_count_d = err_count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (reject && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
  end

  // Storage is data-only: nothing reads an entry until count says it was written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {enc_type, enc_word};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  // Head is forced to zero while empty so stale or uninitialised entries never show.
  assign head            = mem_q[rd_ptr_q];
  assign out_instruction = out_valid ? head[WORD_SIZE-1:0] : '0;
  assign out_type        = out_valid ? head[EW-1:WORD_SIZE] : 3'b000;
  assign err             = err_q;
  assign err_count       = err_count_q;
  assign count           = count_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: vector table, scoreboard queue,
// and hand-written sequences for backpressure, push/pop overlap and mid-stream reset.
module tb_instruction_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [2:0]  out_type;
  logic        err;
  logic [7:0]  err_count;
  logic [2:0]  count;

  instruction_encoder #(.DEPTH(DEPTH), .WORD_SIZE(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_type(out_type),
    .err(err), .err_count(err_count), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    bit          rej;
    logic [31:0] exp_w;
    logic [2:0]  exp_t;
  } vec_t;

  vec_t        vec [20];
  logic [34:0] sb [$];
  int          tests = 0;
  int          fails = 0;
  bit          err_exp = 1'b0;
  int          errcnt_m = 0;
  bit          acc = 1'b0;
  bit          cur_rej = 1'b0;
  logic [31:0] cur_w = '0;
  logic [2:0]  cur_t = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare against the model at the falling edge, then advance the
  // model with what the next rising edge will do.
  task automatic tick();
    int sz;
    logic [34:0] e;
    @(negedge clk);
    sz = sb.size();
    chk("count", 32'(count), 32'(sz));
    chk("in_ready", 32'(in_ready), 32'(sz < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(sz != 0));
    chk("err", 32'(err), 32'(err_exp));
    chk("err_count", 32'(err_count), 32'(errcnt_m));
    acc = in_valid && (sz < DEPTH);
    if (out_ready && sz != 0) begin
      e = sb.pop_front();
      chk("out_instruction", out_instruction, e[31:0]);
      chk("out_type", 32'(out_type), 32'(e[34:32]));
    end
    err_exp = acc && cur_rej;
    if (acc) begin
      if (cur_rej) begin
        if (errcnt_m < 255) errcnt_m++;
      end else begin
        sb.push_back({cur_t, cur_w});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_opcode = v.op;  in_rd = v.rd;  in_rs1 = v.rs1;  in_rs2 = v.rs2;
    in_funct3 = v.f3;  in_funct7 = v.f7;  in_imm = v.imm;
    cur_rej = v.rej;  cur_w = v.exp_w;  cur_t = v.exp_t;
  endtask

  task automatic send(input vec_t v);
    drive(v);
    in_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 30 && !acc; k++) tick();
    chk("send_accepted", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && sb.size() != 0; k++) tick();
    chk("drain_empty", 32'(sb.size()), 32'd0);
    tick();
  endtask

  function automatic vec_t lui_vec(input int i);
    vec_t v;
    v = '{7'h37, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, 1'b0, 32'h0, 3'd3};
    v.imm   = {20'(i * 7 + 1), 12'h000};
    v.exp_w = {v.imm[31:12], v.rd, 7'h37};
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0]  = '{7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'h00000000, 1'b0, 32'h003100B3, 3'd0};
    vec[1]  = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 1'b0, 32'hFFF00093, 3'd1};
    vec[2]  = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 1'b0, 32'h123452B7, 3'd3};
    vec[3]  = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFC, 1'b0, 32'hFE208EE3, 3'd4};
    vec[4]  = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800, 1'b0, 32'h001000EF, 3'd5};
    vec[5]  = '{7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 32'h00000008, 1'b0, 32'h00512423, 3'd2};
    vec[6]  = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800, 1'b1, 32'h0, 3'd0};
    vec[7]  = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00000003, 1'b1, 32'h0, 3'd0};
    vec[8]  = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000001, 1'b1, 32'h0, 3'd0};
    vec[9]  = '{7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'h00000000, 1'b1, 32'h0, 3'd0};
    vec[10] = '{7'h67, 5'd1, 5'd5, 5'd0, 3'd0, 7'h00, 32'hFFFFF800, 1'b0, 32'h800280E7, 3'd1};
    vec[11] = '{7'h17, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF000, 1'b0, 32'hFFFFF197, 3'd3};
    vec[12] = '{7'h03, 5'd4, 5'd2, 5'd0, 3'd2, 7'h00, 32'h000007FF, 1'b0, 32'h7FF12203, 3'd1};
    vec[13] = '{7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFE, 1'b0, 32'hFFFFF06F, 3'd5};
    vec[14] = '{7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 32'hFFFFF7FF, 1'b1, 32'h0, 3'd0};
    vec[15] = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00100000, 1'b1, 32'h0, 3'd0};
    vec[16] = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00001000, 1'b1, 32'h0, 3'd0};
    vec[17] = '{7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'hDEADBEEF, 1'b0, 32'h405201B3, 3'd0};
    vec[18] = '{7'h13, 5'd2, 5'd3, 5'd31, 3'd1, 7'h7F, 32'h00000405, 1'b0, 32'h40519113, 3'd1};
    vec[19] = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd1, 7'h00, 32'h00000FFE, 1'b0, 32'h7E001FE3, 3'd4};

    reset_n = 1'b0;
    in_valid = 1'b0;  out_ready = 1'b1;
    in_opcode = '0;  in_rd = '0;  in_rs1 = '0;  in_rs2 = '0;
    in_funct3 = '0;  in_funct7 = '0;  in_imm = '0;
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instruction", out_instruction, 32'd0);
    chk("rst_out_type", 32'(out_type), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Spec vectors including the four rejections, each drained individually.
    for (int i = 0; i < 10; i++) begin
      send(vec[i]);
      drain();
    end
    chk("err_count_after_rejects", 32'(err_count), 32'd4);

    // Further encodes and boundary immediates, back to back.
    for (int i = 10; i < 20; i++) send(vec[i]);
    drain();

    // Back-to-back rejections until the counter saturates.
    for (int i = 0; i < 300; i++) send(vec[9]);
    tick();
    chk("err_count_saturated", 32'(err_count), 32'd255);

    // Backpressure: fill, verify the fifth request is held off, then drain in order.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(lui_vec(i));
    tick();
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive(vec[0]);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fifth_not_accepted", 32'(acc), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("drained_in_four", 32'(sb.size()), 32'd0);
    tick();

    // Simultaneous push and pop at occupancy 2; pointers wrap several times.
    out_ready = 1'b0;
    send(lui_vec(10));
    send(lui_vec(11));
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(lui_vec(12 + i));
      in_valid = 1'b1;
      tick();
      chk("pushpop_accepted", 32'(acc), 32'd1);
      chk("pushpop_count", 32'(count), 32'd2);
    end
    in_valid = 1'b0;
    drain();

    // Reset with three entries queued.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(lui_vec(40 + i));
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    errcnt_m = 0;
    err_exp = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(vec[5]);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Packs RV32I instruction fields (opcode, registers, funct3/funct7, immediate) into 32-bit instruction words, the inverse of the opcode-to-type decode. Sits between the test/program-generation front end and instruction memory or the fetch path. Classifies each request by opcode, range-checks the immediate for that format, and buffers legal words in a small FIFO with valid/ready handshakes on both sides.

## Interface
- `DEPTH`, 4: output FIFO entries; power of two, ≥2.
- `WORD_SIZE`, 32: instruction width; fixed at 32.

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: encoder accepts request this cycle.
- `in_opcode` in 7: one of the opcode constants from `constants.svh`: op, op_imm, jalr, load, branch, store, lui, auipc, jal.
- `in_rd`, `in_rs1`, `in_rs2` in 5 each: register indices.
- `in_funct3` in 3, `in_funct7` in 7: function fields.
- `in_imm` in 32: signed immediate, byte offset for B/J, full upper value for U.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer takes head.
- `out_instruction` out 32: encoded word at head.
- `out_type` out 3: `INSTRUCTION_TYPE_*` of head (R=000, I=001, S=010, U=011, B=100, J=101).
- `err` out 1: one-cycle pulse when an accepted request was rejected.
- `err_count` out 8: saturating count of rejected requests.
- `count` out $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- Handshake: transfer occurs when `in_valid && in_ready`. `in_ready = (count < DEPTH)`, with no pass-through when full. Pop occurs when `out_valid && out_ready`.
- Type from opcode: op→R; op_imm, jalr, load→I; store→S; branch→B; lui, auipc→U; jal→J; any other value is illegal.
- Packing, with bit [6:0] = opcode:
  - R: {funct7, rs2, rs1, funct3, rd}.
  - I: {imm[11:0], rs1, funct3, rd}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0]}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11]}.
  - U: {imm[31:12], rd}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd}.
- Unused fields for a type are ignored. For example, funct7 and rs2 are ignored for I-type; shift-immediate funct7 is supplied by the caller in `in_imm[11:5]`.
- Legality checks; a failure rejects the request:
  - I/S: `in_imm` equals the sign-extension of `in_imm[11:0]`.
  - B: equals the sign-extension of `in_imm[12:0]`, and `in_imm[0]==0`.
  - J: equals the sign-extension of `in_imm[20:0]`, and `in_imm[0]==0`.
  - U: `in_imm[11:0]==0`.
  - R: always legal.
  - Illegal opcode: rejected.
- Rejected request:
  - Still consumes the handshake.
  - Not pushed.
  - `err` pulses the next cycle.
  - `err_count` increments, holding at 255.
- FIFO:
  - Circular buffer with read and write pointers that wrap modulo DEPTH.
  - Push and pop in the same cycle: occupancy unchanged, both pointers advance.
  - Pop when empty is impossible because `out_valid=0`.
  - A rejected request with a simultaneous pop only decrements.
- Outputs `out_instruction` and `out_type` come from registered FIFO storage at the read pointer. They are stable while `out_valid && !out_ready`.

## Timing
- Reset (async assert, sync release): `count=0`, `out_valid=0`, `out_instruction=0`, `out_type=0`, `err=0`, `err_count=0`, pointers 0, `in_ready=1` after assertion.
- Latency: request accepted at edge N appears with `out_valid=1` after edge N (visible cycle N+1), when the FIFO was empty.
- Throughput: one request per cycle when `out_ready` is held high.
- `err` asserts in the cycle after the accepting edge, for exactly one cycle per rejection. Back-to-back rejections hold `err` high.
- `in_ready` deasserts in the cycle after the edge that makes `count==DEPTH`. It reasserts in the cycle after the first pop.
- Reset mid-operation: all FIFO contents are discarded and `err_count` is cleared. A request in flight is lost.

## Test plan
- Reset then single encodes, `out_ready=1`:
  - op, rd=1, rs1=2, rs2=3, f3=0, f7=0 → 0x003100B3, type 000.
  - op_imm, rd=1, rs1=0, imm=-1 → 0xFFF00093, type 001.
  - lui, rd=5, imm=0x12345000 → 0x123452B7, type 011.
- Branch/jump packing:
  - branch, rs1=1, rs2=2, f3=0, imm=-4 → 0xFE208EE3, type 100.
  - jal, rd=1, imm=2048 → 0x001000EF, type 101.
  - store, rs1=2, rs2=5, f3=2, imm=8 → 0x00512423, type 010.
- Rejections:
  - op_imm imm=2048 → `err` pulse, nothing queued.
  - branch imm=3 → error.
  - lui imm=0x1 → error.
  - opcode 0x7F → error.
  - `err_count` = 4 afterwards.
  - Separately, 300 rejections → `err_count` saturates at 255.
- Backpressure:
  - With `out_ready=0`, push 4 legal words → `in_ready=0`, `count=4`; a 5th request is not accepted.
  - Then `out_ready=1` → the four words emerge in order, one per cycle.
- Simultaneous push/pop with occupancy at 2 for 20 cycles → `count` stays 2, pointers wrap, order preserved.
- Assert `reset_n` low mid-stream with 3 entries queued → `out_valid` drops immediately, `count=0`, `err_count=0`, and the first post-reset word is the first request after release.
